// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, datapath widths and FSM encoding.
package alu_pkg;
  localparam int ALU_DW = 8;
  localparam int ALU_RW = 16;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL  = 3'b010;
  localparam logic [OP_W-1:0] OP_INV  = 3'b011;
  localparam logic [OP_W-1:0] OP_AND  = 3'b100;
  localparam logic [OP_W-1:0] OP_OR   = 3'b101;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b110;
  localparam logic [OP_W-1:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; push is ignored when full, pop when empty.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/alu_cmd_issue.sv
// Issue stage feeding the combinational ALU: buffers commands, drives registered operands,
// captures the result and returns it with its tag. Optional res_zero/res_hi via `RES_FLAGS_EN.
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ALU_DW-1:0]       cmd_a,
  input  logic [ALU_DW-1:0]       cmd_b,
  input  logic [OP_W-1:0]         cmd_op,
  input  logic [TAG_W-1:0]        cmd_tag,
  output logic [ALU_DW-1:0]       alu_a,
  output logic [ALU_DW-1:0]       alu_b,
  output logic [OP_W-1:0]         alu_op,
  input  logic [ALU_RW-1:0]       alu_r,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ALU_RW-1:0]       res_data,
  output logic [TAG_W-1:0]        res_tag,
  output logic [OP_W-1:0]         res_op,
`ifdef RES_FLAGS_EN
  output logic                    res_zero,
  output logic                    res_hi,
`endif
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int CW = 2*ALU_DW + OP_W + TAG_W;

  logic [CW-1:0]      head;
  logic               fifo_full, fifo_empty, push, pop;
  state_e             state_q, state_d;
  logic [ALU_DW-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d, res_op_q, res_op_d;
  logic [TAG_W-1:0]   tag_q, tag_d, res_tag_q, res_tag_d;
  logic [ALU_RW-1:0]  res_data_q, res_data_d;
  logic               res_valid_q, res_valid_d;
`ifdef RES_FLAGS_EN
  logic               res_zero_q, res_zero_d, res_hi_q, res_hi_d;
`endif

  // No bypass: a full FIFO refuses even when it pops this cycle.
  assign cmd_ready = rst_n && !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  alu_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({cmd_tag, cmd_op, cmd_b, cmd_a}),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (res_ready) state_d = fifo_empty ? ST_IDLE : ST_EXEC;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    tag_d       = tag_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    res_op_d    = res_op_q;
`ifdef RES_FLAGS_EN
    res_zero_d  = res_zero_q;
    res_hi_d    = res_hi_q;
`endif
    case (state_q)
      ST_IDLE: pop = !fifo_empty;
      ST_EXEC: begin
        res_valid_d = 1'b1;
        res_data_d  = alu_r;
        res_tag_d   = tag_q;
        res_op_d    = alu_op_q;
`ifdef RES_FLAGS_EN
        res_zero_d  = (alu_r == '0);
        res_hi_d    = |alu_r[ALU_RW-1:ALU_DW];
`endif
      end
      ST_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          pop         = !fifo_empty;
        end
      end
      default: ;
    endcase
    if (pop) begin
      {tag_d, alu_op_d, alu_b_d, alu_a_d} = head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      tag_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_op_q    <= '0;
`ifdef RES_FLAGS_EN
      res_zero_q  <= 1'b0;
      res_hi_q    <= 1'b0;
`endif
    end else begin
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      tag_q       <= tag_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_op_q    <= res_op_d;
`ifdef RES_FLAGS_EN
      res_zero_q  <= res_zero_d;
      res_hi_q    <= res_hi_d;
`endif
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign res_op    = res_op_q;
`ifdef RES_FLAGS_EN
  assign res_zero  = res_zero_q;
  assign res_hi    = res_hi_q;
`endif
endmodule
